dma_io2_fetch: RTL

- DMA channel engine sitting directly upstream of the IO device 2 buffer.
- Reads it through the chip-select/index port and writes the words into system memory.
- Started by software config; transfer gated by the device's GPIO2 request level; asserts ack2 while servicing.
- Pure read-from-device / write-to-memory path, one word per fixed 3-cycle slot.

---
 rtl/dma_pkg.sv | 30 +++
 rtl/dma_io2_fetch.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the IO device 2 fetch DMA channel.
// State encoding, default widths and the device index layout.
package dma_pkg;

    localparam int DATA_W    = 32;
    localparam int MEM_AW    = 13;
    localparam int BUF_DEPTH = 32;
    localparam int IO_CS_BIT = 8;
    localparam int IO_IDX_W  = 9;
    localparam int LEN_W     = 6;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        READ,
        CAPT,
        CLR,
        WRITE,
        DONE
    } state_t;

    // Device index: chip select on top, zero-extended buffer word pointer below.
    function automatic logic [IO_IDX_W-1:0] io_idx(
        input logic             cs,
        input logic [LEN_W-1:0] w
    );
        io_idx = {cs, {(IO_IDX_W-1-LEN_W){1'b0}}, w};
    endfunction

endpackage

// File: rtl/dma_io2_fetch.sv
// DMA channel: reads IO device 2 buffer words and writes them to memory.
// Define DMA_IO2_CLEAR_EN to zero each consumed device slot (4 cycles/word).
module dma_io2_fetch
    import dma_pkg::*;
#(
    parameter int DATA_W    = dma_pkg::DATA_W,
    parameter int MEM_AW    = dma_pkg::MEM_AW,
    parameter int BUF_DEPTH = dma_pkg::BUF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic [MEM_AW-1:0]   cfg_base,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic                gpio2,
    output logic                ack2,
    output logic [IO_IDX_W-1:0] index,
    output logic                iowrite2,
    input  logic [DATA_W-1:0]   io_rdata,
    output logic [DATA_W-1:0]   io_wdata,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    xfer_cnt
);

    state_t                r_state;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_w;
    logic [MEM_AW-1:0]     r_a;
    logic                  r_ack2;
    logic [IO_IDX_W-1:0]   r_index;
    logic                  r_iowrite2;
    logic                  r_mem_we;
    logic [MEM_AW-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic [LEN_W-1:0]      r_xfer_cnt;

    logic [LEN_W-1:0]      w_len;
    logic [LEN_W-1:0]      w_w_nxt;

    assign w_len   = (int'(cfg_len) > BUF_DEPTH) ? LEN_W'(BUF_DEPTH) : cfg_len;
    assign w_w_nxt = r_w + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_w         <= '0;
            r_a         <= '0;
            r_ack2      <= 1'b0;
            r_index     <= '0;
            r_iowrite2  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_xfer_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_state    <= ARMED;
                        r_busy     <= 1'b1;
                        r_xfer_cnt <= '0;
                        r_w        <= '0;
                        r_a        <= cfg_base;
                        r_len      <= w_len;
                    end
                end
                ARMED: begin
                    // Request level only matters here; a later drop does not stall.
                    if (r_len == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (gpio2) begin
                        r_state    <= READ;
                        r_ack2     <= 1'b1;
                        r_index    <= io_idx(1'b1, r_w);
                        r_iowrite2 <= 1'b0;
                    end
                end
                READ: begin
                    r_state <= CAPT;
                end
                CAPT: begin
                    r_mem_wdata <= io_rdata;
`ifdef DMA_IO2_CLEAR_EN
                    r_state    <= CLR;
                    r_iowrite2 <= 1'b1;
`else
                    r_state    <= WRITE;
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= r_a;
                    r_index    <= io_idx(1'b0, r_w);
                    r_iowrite2 <= 1'b1;
`endif
                end
                CLR: begin
                    r_state    <= WRITE;
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= r_a;
                    r_index    <= io_idx(1'b0, r_w);
                end
                WRITE: begin
                    r_mem_we   <= 1'b0;
                    r_w        <= w_w_nxt;
                    r_a        <= r_a + 1'b1;
                    r_xfer_cnt <= r_xfer_cnt + 1'b1;
                    if (w_w_nxt == r_len) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_ack2  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_index <= '0;
                    end else begin
                        r_state    <= READ;
                        r_index    <= io_idx(1'b1, w_w_nxt);
                        r_iowrite2 <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack2      = r_ack2;
    assign index     = r_index;
    assign iowrite2  = r_iowrite2;
    assign io_wdata  = '0;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
